if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, requests words from instruction memory over
//  a valid/ready handshake and drives the IF/ID register whose instruction word

---
 rtl/if_fetch_stage.sv | 116 +++++++++++
 tb/tb_if_fetch_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time over a
// valid/ready handshake, and fills the IF/ID register consumed by decode.
module if_fetch_stage #(
   parameter int                         WORD_BITWIDTH = 32,
   parameter int                         ADDR_BITWIDTH = 32,
   parameter logic [ADDR_BITWIDTH-1:0]   RESET_PC      = 32'h00000000,
   parameter int                         PC_STEP       = 4,
   parameter logic [WORD_BITWIDTH-1:0]   NOP_INST      = 32'h00000013
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      imem_req_valid,
   input  logic                      imem_req_ready,
   output logic [ADDR_BITWIDTH-1:0]  imem_addr,
   input  logic                      imem_resp_valid,
   output logic                      imem_resp_ready,
   input  logic [WORD_BITWIDTH-1:0]  imem_resp_data,
   input  logic                      id_stall,
   input  logic                      branch_taken,
   input  logic [ADDR_BITWIDTH-1:0]  branch_target,
   output logic                      if_id_valid,
   output logic [WORD_BITWIDTH-1:0]  if_id_instruction,
   output logic [ADDR_BITWIDTH-1:0]  if_id_pc
);

   typedef enum logic {
      ST_REQ,
      ST_WAIT
   } state_t;

   state_t                     state;
   state_t                     next_state;
   logic [ADDR_BITWIDTH-1:0]   pc;
   logic                       kill;

   logic                       req_fire;
   logic                       resp_fire;
   logic                       load;
   logic                       outstanding_after;
   logic [ADDR_BITWIDTH-1:0]   target_aligned;

   // A response is taken whenever the handshake completes; whether it is kept is decided by kill/redirect.
   assign req_fire          = imem_req_valid & imem_req_ready;
   assign resp_fire         = (state == ST_WAIT) & imem_resp_valid & imem_resp_ready;
   assign load              = resp_fire & ~kill & ~branch_taken;
   assign outstanding_after = ((state == ST_WAIT) & ~resp_fire) | req_fire;
   assign target_aligned    = branch_target & ~ADDR_BITWIDTH'(3);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_REQ;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (branch_taken) begin
         next_state = outstanding_after ? ST_WAIT : ST_REQ;
      end else begin
         case (state)
            ST_REQ:  if (imem_req_ready) next_state = ST_WAIT;
            ST_WAIT: if (resp_fire)      next_state = ST_REQ;
            default: next_state = ST_REQ;
         endcase
      end
   end

   always_comb begin
      imem_req_valid  = (state == ST_REQ);
      imem_resp_ready = (state == ST_WAIT) & (kill | ~if_id_valid | ~id_stall);
      imem_addr       = pc;
   end

   // kill marks the single in-flight response that belongs to the pre-redirect path.
   always_ff @(posedge clk) begin
      if (rst) begin
         kill <= 1'b0;
      end else if (branch_taken) begin
         kill <= outstanding_after;
      end else if (resp_fire && kill) begin
         kill <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (branch_taken) begin
         pc <= target_aligned;
      end else if (load) begin
         pc <= pc + ADDR_BITWIDTH'(PC_STEP);
      end
   end

   // Redirect flushes, a kept response loads, otherwise decode drains the register unless stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_valid       <= 1'b0;
         if_id_instruction <= NOP_INST;
         if_id_pc          <= RESET_PC;
      end else if (branch_taken) begin
         if_id_valid       <= 1'b0;
         if_id_instruction <= NOP_INST;
      end else if (load) begin
         if_id_valid       <= 1'b1;
         if_id_instruction <= imem_resp_data;
         if_id_pc          <= pc;
      end else if (if_id_valid && !id_stall) begin
         if_id_valid       <= 1'b0;
         if_id_instruction <= NOP_INST;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed and randomized checks of if_fetch_stage against a transaction-level
// model that tracks "request in flight", "stale response pending" and the IF/ID slot.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic        imem_resp_ready;
   logic [31:0] imem_resp_data;
   logic        id_stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        if_id_valid;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;
   bit          m_busy;
   bit          m_stale;
   bit          m_valid;

   if_fetch_stage dut (
      .clk               (clk),
      .rst               (rst),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_addr         (imem_addr),
      .imem_resp_valid   (imem_resp_valid),
      .imem_resp_ready   (imem_resp_ready),
      .imem_resp_data    (imem_resp_data),
      .id_stall          (id_stall),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .if_id_valid       (if_id_valid),
      .if_id_instruction (if_id_instruction),
      .if_id_pc          (if_id_pc)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_pc    = 32'h0;
      m_instr = NOP;
      m_ipc   = 32'h0;
      m_busy  = 1'b0;
      m_stale = 1'b0;
      m_valid = 1'b0;
   endtask

   // Drive one cycle of inputs (called at negedge), check outputs, then advance DUT and model.
   task automatic applyStimulus(input bit r, input bit rq_rdy, input bit want_resp,
                                input logic [31:0] data, input bit stall,
                                input bit br, input logic [31:0] tgt);
      bit          exp_resp_ready;
      bit          took;
      bit          acc;
      logic [31:0] old_pc;
      rst            = r;
      imem_req_ready = rq_rdy;
      imem_resp_valid = want_resp && m_busy;
      imem_resp_data = data;
      id_stall       = stall;
      branch_taken   = br;
      branch_target  = tgt;
      #1;
      exp_resp_ready = m_busy && (m_stale || !m_valid || !stall);
      checkOutput("req_valid",  32'(imem_req_valid),  32'(!m_busy));
      checkOutput("resp_ready", 32'(imem_resp_ready), 32'(exp_resp_ready));
      checkOutput("imem_addr",  imem_addr,            m_pc);
      checkOutput("if_id_valid", 32'(if_id_valid),    32'(m_valid));
      checkOutput("if_id_instr", if_id_instruction,   m_instr);
      checkOutput("if_id_pc",   if_id_pc,             m_ipc);

      took   = m_busy && imem_resp_valid && exp_resp_ready;
      acc    = !m_busy && rq_rdy;
      old_pc = m_pc;
      @(posedge clk);
      if (r) begin
         modelReset();
      end else if (br) begin
         m_pc    = {tgt[31:2], 2'b00};
         m_valid = 1'b0;
         m_instr = NOP;
         m_busy  = (m_busy && !took) || acc;
         m_stale = m_busy;
      end else begin
         if (took && !m_stale) begin
            m_valid = 1'b1;
            m_instr = data;
            m_ipc   = old_pc;
            m_pc    = old_pc + 32'd4;
         end else if (m_valid && !stall) begin
            m_valid = 1'b0;
            m_instr = NOP;
         end
         if (took) m_stale = 1'b0;
         if (acc) m_busy = 1'b1;
         else if (took) m_busy = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      id_stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      modelReset();
      $display("[TB] reset state");
      applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
      checkOutput("rst_addr",  imem_addr, 32'h0);
      checkOutput("rst_req",   32'(imem_req_valid), 32'd1);
      checkOutput("rst_valid", 32'(if_id_valid), 32'd0);
      checkOutput("rst_instr", if_id_instruction, 32'h00000013);

      $display("[TB] streaming fetch");
      applyStimulus(0, 1, 1, 32'h00500093, 0, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h00500093, 0, 0, 32'h0);
      checkOutput("s_instr0", if_id_instruction, 32'h00500093);
      checkOutput("s_pc0",    if_id_pc, 32'h0);
      checkOutput("s_addr4",  imem_addr, 32'h4);
      applyStimulus(0, 1, 1, 32'h00A00113, 0, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h00A00113, 0, 0, 32'h0);
      checkOutput("s_instr1", if_id_instruction, 32'h00A00113);
      checkOutput("s_pc1",    if_id_pc, 32'h4);
      applyStimulus(0, 1, 1, 32'h00100193, 0, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h00100193, 0, 0, 32'h0);
      checkOutput("s_addr12", imem_addr, 32'hC);

      $display("[TB] decode stall");
      applyStimulus(0, 1, 1, 32'h00200213, 1, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 1, 32'h00200213, 1, 0, 32'h0);
         checkOutput("st_rready", 32'(imem_resp_ready), 32'd0);
         checkOutput("st_instr",  if_id_instruction, 32'h00100193);
         checkOutput("st_addr",   imem_addr, 32'hC);
      end
      applyStimulus(0, 1, 1, 32'h00200213, 0, 0, 32'h0);
      checkOutput("st_rel_instr", if_id_instruction, 32'h00200213);
      checkOutput("st_rel_pc",    if_id_pc, 32'hC);

      $display("[TB] redirect while waiting");
      applyStimulus(0, 1, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 1, 0, 32'h0, 0, 1, 32'h103);
      checkOutput("rd_addr",  imem_addr, 32'h100);
      checkOutput("rd_valid", 32'(if_id_valid), 32'd0);
      checkOutput("rd_instr", if_id_instruction, NOP);
      applyStimulus(0, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0);
      checkOutput("rd_drop_valid", 32'(if_id_valid), 32'd0);
      checkOutput("rd_req_valid",  32'(imem_req_valid), 32'd1);
      applyStimulus(0, 1, 1, 32'h00300293, 0, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h00300293, 0, 0, 32'h0);
      checkOutput("rd_first_pc",    if_id_pc, 32'h100);
      checkOutput("rd_first_instr", if_id_instruction, 32'h00300293);

      $display("[TB] redirect with response and stall");
      applyStimulus(0, 1, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 0, 1, 32'hBADC0DE0, 1, 1, 32'h102);
      checkOutput("rs_valid", 32'(if_id_valid), 32'd0);
      checkOutput("rs_req",   32'(imem_req_valid), 32'd1);
      checkOutput("rs_addr",  imem_addr, 32'h100);
      applyStimulus(0, 1, 1, 32'h00700393, 0, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h00700393, 0, 0, 32'h0);
      checkOutput("rs_nokill", if_id_instruction, 32'h00700393);

      $display("[TB] reset with stale response pending");
      applyStimulus(0, 1, 0, 32'h0, 0, 0, 32'h0);
      applyStimulus(0, 1, 0, 32'h0, 0, 1, 32'h200);
      applyStimulus(1, 1, 0, 32'h0, 0, 0, 32'h0);
      checkOutput("rk_addr",  imem_addr, 32'h0);
      checkOutput("rk_valid", 32'(if_id_valid), 32'd0);
      checkOutput("rk_instr", if_id_instruction, NOP);
      applyStimulus(0, 1, 1, 32'h00400313, 0, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h00400313, 0, 0, 32'h0);
      checkOutput("rk_load", if_id_instruction, 32'h00400313);

      $display("[TB] pc wraparound");
      applyStimulus(0, 0, 0, 32'h0, 0, 1, 32'hFFFFFFFF);
      checkOutput("wr_addr", imem_addr, 32'hFFFFFFFC);
      applyStimulus(0, 1, 1, 32'h00800413, 0, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'h00800413, 0, 0, 32'h0);
      checkOutput("wr_next", imem_addr, 32'h0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(63) == 0), ($urandom_range(1) == 1),
                       ($urandom_range(9) < 6), $urandom(), ($urandom_range(9) < 3),
                       ($urandom_range(9) == 0), $urandom());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
